// File: rtl/multirate_v3_tap_accumulator.sv
// Polyphase tap accumulator: sums TAPS signed products per output sample, then
// rounds, scales by SHIFT fraction bits and saturates onto a one-deep ready/valid output.
module multirate_v3_tap_accumulator #(
    parameter int PROD_WIDTH = 26,
    parameter int ACC_WIDTH  = 32,
    parameter int OUT_WIDTH  = 16,
    parameter int TAPS       = 16,
    parameter int SHIFT      = 9
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  clear,
    input  logic [PROD_WIDTH-1:0] prod_data,
    input  logic                  prod_valid,
    output logic                  prod_ready,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  sat_flag,
    output logic [7:0]            tap_cnt
);

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} out_state_t;

    localparam logic [7:0] LAST_TAP = 8'(TAPS - 1);
    localparam logic signed [ACC_WIDTH:0] RND_BIAS = {{ACC_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
    localparam logic signed [ACC_WIDTH:0] OUT_MAX =
        {{(ACC_WIDTH-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [ACC_WIDTH:0] OUT_MIN =
        {{(ACC_WIDTH-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    localparam logic [OUT_WIDTH-1:0] SAT_POS = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    localparam logic [OUT_WIDTH-1:0] SAT_NEG = {1'b1, {(OUT_WIDTH-1){1'b0}}};

    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [7:0]                  tap_cnt_q, tap_cnt_d;
    logic [OUT_WIDTH-1:0]        out_data_q, out_data_d;
    out_state_t                  state_q, state_d;
    logic                        sat_q, sat_d;

    logic                        last_tap;
    logic                        accept;
    logic                        final_accept;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] sum;
    logic signed [ACC_WIDTH:0]   rnd;
    logic signed [ACC_WIDTH:0]   r;
    logic                        sat_hi;
    logic                        sat_lo;

    // Only the final tap waits on a stalled output; earlier taps of the next frame flow freely.
    assign last_tap     = (tap_cnt_q == LAST_TAP);
    assign prod_ready   = !clear && !(last_tap && (state_q == FULL) && !out_ready);
    assign accept       = prod_valid && prod_ready;
    assign final_accept = accept && last_tap;

    assign prod_ext = {{(ACC_WIDTH-PROD_WIDTH){prod_data[PROD_WIDTH-1]}}, prod_data};
    assign sum      = acc_q + prod_ext;
    // One guard bit keeps the rounding bias from wrapping a near-full-scale sum.
    assign rnd      = {sum[ACC_WIDTH-1], sum} + RND_BIAS;
    assign r        = rnd >>> SHIFT;
    assign sat_hi   = (r > OUT_MAX);
    assign sat_lo   = (r < OUT_MIN);

    always_comb begin
        acc_d      = acc_q;
        tap_cnt_d  = tap_cnt_q;
        out_data_d = out_data_q;
        sat_d      = sat_q;
        if (clear) begin
            acc_d     = '0;
            tap_cnt_d = '0;
        end else if (accept) begin
            if (last_tap) begin
                acc_d     = '0;
                tap_cnt_d = '0;
                sat_d     = sat_q | sat_hi | sat_lo;
                if (sat_hi) begin
                    out_data_d = SAT_POS;
                end else if (sat_lo) begin
                    out_data_d = SAT_NEG;
                end else begin
                    out_data_d = r[OUT_WIDTH-1:0];
                end
            end else begin
                acc_d     = (tap_cnt_q == 8'd0) ? prod_ext : sum;
                tap_cnt_d = tap_cnt_q + 8'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: state_d = final_accept ? FULL : EMPTY;
            FULL: begin
                if (final_accept) begin
                    state_d = FULL;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q      <= '0;
            tap_cnt_q  <= '0;
            out_data_q <= '0;
            state_q    <= EMPTY;
            sat_q      <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            tap_cnt_q  <= tap_cnt_d;
            out_data_q <= out_data_d;
            state_q    <= state_d;
            sat_q      <= sat_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = (state_q == FULL);
    assign sat_flag  = sat_q;
    assign tap_cnt   = tap_cnt_q;

endmodule

// File: tb/tb_multirate_v3_tap_accumulator.sv
// Bench for multirate_v3_tap_accumulator: queue-based frame model checked every cycle,
// directed literal scenarios, then randomized traffic with backpressure and clears.
module tb_multirate_v3_tap_accumulator;

    localparam int TAPS  = 4;
    localparam int SHIFT = 9;
    localparam int PW    = 26;
    localparam int OW    = 16;

    logic                 ap_clk     = 1'b0;
    logic                 ap_rst_n   = 1'b0;
    logic                 clear      = 1'b0;
    logic signed [PW-1:0] prod_data  = '0;
    logic                 prod_valid = 1'b0;
    logic                 out_ready  = 1'b1;
    logic                 prod_ready;
    logic signed [OW-1:0] out_data;
    logic                 out_valid;
    logic                 sat_flag;
    logic [7:0]           tap_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    multirate_v3_tap_accumulator #(
        .PROD_WIDTH(PW), .ACC_WIDTH(32), .OUT_WIDTH(OW), .TAPS(TAPS), .SHIFT(SHIFT)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .clear(clear),
        .prod_data(prod_data), .prod_valid(prod_valid), .prod_ready(prod_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .sat_flag(sat_flag), .tap_cnt(tap_cnt)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    endtask

    // ---------------- behavioural model ----------------
    longint m_prods[$];
    logic   m_valid = 1'b0;
    longint m_data  = 0;
    logic   m_sat   = 1'b0;
    int     n_out   = 0;
    logic   exp_ready;
    longint m_sum, m_r;

    always @(negedge ap_clk) begin
        if (!ap_rst_n) begin
            m_prods.delete();
            m_valid = 1'b0;
            m_data  = 0;
            m_sat   = 1'b0;
            chk("rst_out_valid", out_valid, 0);
            chk("rst_tap_cnt", tap_cnt, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_sat_flag", sat_flag, 0);
        end else begin
            exp_ready = !clear && !(m_prods.size() == TAPS-1 && m_valid && !out_ready);
            chk("prod_ready", prod_ready, exp_ready);
            chk("out_valid", out_valid, m_valid);
            chk("out_data", out_data, m_data);
            chk("sat_flag", sat_flag, m_sat);
            chk("tap_cnt", tap_cnt, m_prods.size());
            if (m_valid && out_ready) begin
                $display("out sample %0d: %0d (sat_flag=%0d)", n_out, m_data, m_sat);
                n_out++;
                m_valid = 1'b0;
            end
            if (clear) begin
                m_prods.delete();
            end else if (prod_valid && exp_ready) begin
                m_prods.push_back(longint'(prod_data));
                if (m_prods.size() == TAPS) begin
                    m_sum = 0;
                    foreach (m_prods[i]) m_sum += m_prods[i];
                    m_sum += 256;
                    m_r = m_sum / 512;
                    if ((m_sum % 512 != 0) && (m_sum < 0)) m_r -= 1;
                    if (m_r > 32767) begin
                        m_data = 32767;
                        m_sat  = 1'b1;
                    end else if (m_r < -32768) begin
                        m_data = -32768;
                        m_sat  = 1'b1;
                    end else begin
                        m_data = m_r;
                    end
                    m_valid = 1'b1;
                    m_prods.delete();
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_prod(input longint p);
        int k;
        @(posedge ap_clk); #1;
        prod_data  = PW'(p);
        prod_valid = 1'b1;
        k = 0;
        @(negedge ap_clk);
        while (!prod_ready && k < 20) begin
            @(negedge ap_clk);
            k++;
        end
        if (!prod_ready) begin
            n_checks++;
            $display("FAIL accept_timeout: product %0d never accepted, got prod_ready=0, expected 1", p);
        end
    endtask

    task automatic idle();
        @(posedge ap_clk); #1;
        prod_valid = 1'b0;
    endtask

    task automatic send_frame(input longint a, input longint b, input longint c, input longint d);
        send_prod(a);
        send_prod(b);
        send_prod(c);
        send_prod(d);
        idle();
    endtask

    task automatic expect_out(input string name, input longint exp_data, input longint exp_sat);
        int k;
        k = 0;
        @(negedge ap_clk);
        while (!out_valid && k < 20) begin
            @(negedge ap_clk);
            k++;
        end
        if (!out_valid) begin
            n_checks++;
            $display("FAIL %s_timeout: got out_valid=0, expected 1", name);
        end else begin
            chk(name, out_data, exp_data);
            chk({name, "_sat"}, sat_flag, exp_sat);
        end
    endtask

    // ---------------- directed + random sequence ----------------
    initial begin
        repeat (2) @(posedge ap_clk);
        #3 ap_rst_n = 1'b1;

        // basic sum
        send_frame(512, 512, 512, 512);
        expect_out("basic", 4, 0);
        @(negedge ap_clk);
        chk("basic_one_cycle", out_valid, 0);
        chk("basic_tap_cnt", tap_cnt, 0);

        // rounding
        send_frame(256, 0, 0, 0);   expect_out("round_p256", 1, 0);
        send_frame(-256, 0, 0, 0);  expect_out("round_m256", 0, 0);
        send_frame(-257, 0, 0, 0);  expect_out("round_m257", -1, 0);
        send_frame(255, 0, 0, 0);   expect_out("round_p255", 0, 0);

        // saturation
        send_frame(1 << 24, 1 << 24, 1 << 24, 1 << 24);
        expect_out("sat_hi", 32767, 1);
        send_frame(-(1 << 25), -(1 << 25), -(1 << 25), -(1 << 25));
        expect_out("sat_lo", -32768, 1);
        send_frame(0, 0, 0, 0);
        expect_out("sat_zero", 0, 1);

        // backpressure: frame A held, frame B streams up to its last tap
        @(posedge ap_clk); #1 out_ready = 1'b0;
        send_prod(512); send_prod(512); send_prod(512); send_prod(512);
        send_prod(1024); send_prod(1024); send_prod(1024);
        @(posedge ap_clk); #1;
        prod_data  = PW'(1024);
        prod_valid = 1'b1;
        repeat (3) begin
            @(negedge ap_clk);
            chk("bp_ready_low", prod_ready, 0);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_data", out_data, 4);
        end
        @(posedge ap_clk); #1 out_ready = 1'b1;
        @(negedge ap_clk);
        chk("bp_pass_ready", prod_ready, 1);
        chk("bp_pass_data_a", out_data, 4);
        @(posedge ap_clk); #1 prod_valid = 1'b0;
        @(negedge ap_clk);
        chk("bp_b_valid", out_valid, 1);
        chk("bp_b_data", out_data, 8);
        @(negedge ap_clk);
        chk("bp_b_once", out_valid, 0);

        // clear mid-frame with a held output
        @(posedge ap_clk); #1 out_ready = 1'b0;
        send_frame(512, 512, 512, 512);
        send_prod(1000); send_prod(1000);
        @(posedge ap_clk); #1;
        clear      = 1'b1;
        prod_data  = PW'(1000);
        prod_valid = 1'b1;
        @(negedge ap_clk);
        chk("clr_ready_low", prod_ready, 0);
        chk("clr_held_valid", out_valid, 1);
        @(posedge ap_clk); #1;
        clear      = 1'b0;
        prod_valid = 1'b0;
        out_ready  = 1'b1;
        @(negedge ap_clk);
        chk("clr_tap_cnt", tap_cnt, 0);
        chk("clr_held_data", out_data, 4);
        chk("clr_held_valid2", out_valid, 1);
        send_frame(512, 512, 512, 512);
        expect_out("clr_after", 4, 1);

        // async reset mid-frame with a held output and sticky saturation
        @(posedge ap_clk); #1 out_ready = 1'b0;
        send_frame(1000, 1000, 1000, 1000);
        send_prod(512); send_prod(512); send_prod(512);
        @(posedge ap_clk); #2;
        ap_rst_n   = 1'b0;
        prod_valid = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_tap_cnt", tap_cnt, 0);
        chk("arst_out_data", out_data, 0);
        chk("arst_sat_flag", sat_flag, 0);
        @(posedge ap_clk); #3;
        ap_rst_n  = 1'b1;
        out_ready = 1'b1;
        send_frame(512, 512, 512, 512);
        expect_out("arst_after", 4, 0);

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            @(posedge ap_clk); #1;
            prod_valid = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            clear      = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 7) == 0) prod_data = PW'($urandom);
            else prod_data = PW'(int'($urandom_range(0, 40000)) - 20000);
        end
        @(posedge ap_clk); #1;
        prod_valid = 1'b0;
        clear      = 1'b0;
        out_ready  = 1'b1;
        repeat (5) @(posedge ap_clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/multirate_v3_tap_accumulator.md
# multirate_v3_tap_accumulator

Downstream partner of the filterbank's 16s×10u tap multipliers. Consumes a stream of signed 26-bit tap products, sums TAPS consecutive products into one output sample, rounds and scales by the coefficient fraction, saturates to 16 bits, and presents the result on a ready/valid output. One output per TAPS accepted products gives the decimation-by-TAPS polyphase sum that feeds the next multirate stage.

## Interface
- PROD_WIDTH, 26: product input width (signed).
- ACC_WIDTH, 32: accumulator width; must be ≥ PROD_WIDTH + ceil(log2(TAPS)).
- OUT_WIDTH, 16: output sample width (signed).
- TAPS, 16: products per output sample; valid range 2..256.
- SHIFT, 9: coefficient fraction bits removed on output; valid range 1..ACC_WIDTH-OUT_WIDTH.

- ap_clk  in  1  sole clock; all state updates on its rising edge.
- ap_rst_n  in  1  asynchronous, active-low reset.
- clear  in  1  synchronous; discards the partial sum and restarts the tap count.
- prod_data  in  PROD_WIDTH  signed tap product.
- prod_valid  in  1  prod_data is valid.
- prod_ready  out  1  block accepts prod_data this cycle.
- out_data  out  OUT_WIDTH  rounded, saturated sum.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts out_data.
- sat_flag  out  1  sticky flag; set when any output saturates.
- tap_cnt  out  8  index of the next product expected (0..TAPS-1).

## Operation
- Accept: a product is accepted when prod_valid && prod_ready && !clear.
- Accumulate: acc is signed, ACC_WIDTH bits, and takes sign-extended products.
  - Tap 0 loads acc ← prod.
  - Taps 1..TAPS-2 update acc ← acc + prod.
  - Tap TAPS-1 forms sum = acc + prod and finalises it.
- Finalise:
  - r = (sum + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, rounding half toward +∞.
  - If r > 2^(OUT_WIDTH-1)-1, out_data = max and sat_flag is set.
  - If r < -2^(OUT_WIDTH-1), out_data = min and sat_flag is set.
  - Otherwise out_data = r[OUT_WIDTH-1:0].
  - out_valid is set and tap_cnt wraps to 0.
- tap_cnt increments by 1 per accepted product and wraps TAPS-1 → 0.
- Output register is one deep. A pending output does not block taps 0..TAPS-2 of the next frame. It blocks only the final tap.
- prod_ready = !clear && !(tap_cnt == TAPS-1 && out_valid && !out_ready). Same-cycle pass-through is allowed: when out_valid && out_ready, the last tap is accepted in that cycle.
- Output state machine, with states EMPTY (out_valid=0) and FULL (out_valid=1):
  - EMPTY → FULL on final-tap accept.
  - FULL → EMPTY on out_ready with no final-tap accept.
  - FULL → FULL on out_ready together with a final-tap accept; the new sample replaces the old one.
  - FULL holds while out_ready=0.
- clear:
  - Sets tap_cnt to 0 and acc to 0, and drops any product presented in the same cycle.
  - Does not affect out_data, out_valid or sat_flag. A held output is still delivered.
  - clear and a final-tap accept cannot coincide, because prod_ready=0 during clear.
- sat_flag is cleared only by reset. clear does not clear it.
- out_data holds its value while out_valid=0.

## Timing
- Reset values (asynchronous, effective immediately on ap_rst_n=0):
  - acc=0, tap_cnt=0, out_data=0, out_valid=0, sat_flag=0.
  - prod_ready=1 once ap_rst_n=1, provided clear=0.
- Reset mid-frame discards the partial sum and any held output. No output is produced for that frame.
- Latency: out_valid rises in the cycle after the final tap is accepted.
- Throughput: 1 product/cycle sustained when out_ready=1, giving 1 output per TAPS cycles.
- prod_ready depends combinationally on out_ready; nothing else is combinational input→output.
- out_data and out_valid are registered and stable while out_valid && !out_ready.
- Back-to-back frames need no idle cycle between them.

## Test plan
All scenarios use TAPS=4, SHIFT=9, PROD_WIDTH=26, OUT_WIDTH=16 unless stated.

- Basic sum: products 512, 512, 512, 512 with out_ready=1 → out_data=4 one cycle after the 4th accept, out_valid high for 1 cycle, sat_flag=0, tap_cnt back to 0.
- Rounding: frame 256,0,0,0 → out_data=1. Frame -256,0,0,0 → 0. Frame -257,0,0,0 → -1. Frame 255,0,0,0 → 0.
- Saturation: four products of 2^24 → out_data=32767, sat_flag=1. Next frame of four products of -2^25 → out_data=-32768, sat_flag stays 1. Frame of zeros → out_data=0, sat_flag stays 1.
- Backpressure: out_ready=0 after frame A, then frame B streamed continuously.
  - Required: the first 3 products of B are accepted.
  - prod_ready=0 on B's 4th product until out_ready=1.
  - Frame A's value is held unchanged throughout.
  - In the out_ready=1 cycle, A is taken and B's last tap is accepted.
  - B is presented in the next cycle. No sample is lost or duplicated.
- Clear mid-frame: products 1000, 1000, clear=1 with prod_valid=1 and data 1000, then 512×4 → first output=4; the dropped product has no effect. A held output pending before clear is still delivered.
- Async reset mid-frame: assert ap_rst_n=0 between taps 2 and 3 → all outputs are at reset values within the same cycle. After release, frame 512×4 → out_data=4.
